// File: rtl/uart_boot_pkg.sv
// Shared definitions for the UART boot loader: state encoding, the default frame
// marker and the timeout counter sizing helper.
package uart_boot_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LEN  = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // The counter only ever holds 0..cycles-1, so $clog2(cycles) bits suffice.
    function automatic int unsigned tmo_cnt_width(input int unsigned cycles);
        return (cycles < 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/boot_word_packer.sv
// Collects payload bytes into little-endian 32-bit words; flags the byte that
// completes a word and presents the fully assembled word alongside it.
module boot_word_packer
    import uart_boot_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  lane_q;
    logic [31:0] asm_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lane_q <= 2'd0;
            asm_q  <= 32'd0;
        end else if (clear) begin
            lane_q <= 2'd0;
        end else if (byte_valid) begin
            asm_q[{lane_q, 3'b000} +: 8] <= byte_data;
            lane_q                       <= lane_q + 2'd1;
        end
    end

    // Lane 3 is taken straight from the input so the word is ready with the strobe.
    always_comb begin
        word_done = byte_valid && (lane_q == 2'd3);
        word      = {byte_data, asm_q[23:0]};
    end

endmodule

// File: rtl/uart_boot_loader.sv
// Frames a UART byte stream into boot RAM words and holds the CPU in reset until a
// complete, checksum-valid image has been written.
module uart_boot_loader
    import uart_boot_pkg::*;
#(
    parameter int unsigned RAM_ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter logic [7:0]  SYNC_BYTE      = SYNC_BYTE_DEFAULT
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      rx_valid,
    input  logic [7:0]                rx_data,
    output logic                      ram_wen,
    output logic [RAM_ADDR_WIDTH-1:0] ram_waddr,
    output logic [31:0]               ram_wdata,
    output logic                      cpu_resetn,
    output logic                      boot_busy,
    output logic                      boot_err
);

    localparam int unsigned           TMO_W    = tmo_cnt_width(TIMEOUT_CYCLES);
    localparam logic [TMO_W-1:0]      TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]                state_q;
    logic [7:0]                len_q;
    logic [7:0]                sum_q;
    logic [RAM_ADDR_WIDTH-1:0] widx_q;
    logic [TMO_W-1:0]          tmo_q;

    logic        in_frame;
    logic        tmo_hit;
    logic        pk_clear;
    logic        pk_valid;
    logic        pk_done;
    logic [31:0] pk_word;

    always_comb begin
        in_frame = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
        tmo_hit  = in_frame && !rx_valid && (tmo_q == TMO_LAST);
        pk_clear = (state_q == ST_LEN);
        pk_valid = (state_q == ST_DATA) && rx_valid;
    end

    boot_word_packer u_packer (
        .clk        (clk),
        .resetn     (resetn),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (rx_data),
        .word_done  (pk_done),
        .word       (pk_word)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            len_q      <= 8'd0;
            sum_q      <= 8'd0;
            widx_q     <= '0;
            tmo_q      <= '0;
            ram_wen    <= 1'b0;
            ram_waddr  <= '0;
            ram_wdata  <= 32'd0;
            cpu_resetn <= 1'b0;
            boot_busy  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            ram_wen <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (rx_valid && (rx_data == SYNC_BYTE)) begin
                        state_q   <= ST_LEN;
                        boot_err  <= 1'b0;
                        boot_busy <= 1'b1;
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        len_q   <= rx_data;
                        widx_q  <= '0;
                        sum_q   <= 8'd0;
                        state_q <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        sum_q <= sum_q + rx_data;
                    end
                    if (pk_done) begin
                        ram_wen   <= 1'b1;
                        ram_waddr <= widx_q;
                        ram_wdata <= pk_word;
                        widx_q    <= widx_q + RAM_ADDR_WIDTH'(1);
                        if (widx_q == RAM_ADDR_WIDTH'(len_q)) begin
                            state_q <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (rx_valid) begin
                        boot_busy <= 1'b0;
                        if (rx_data == sum_q) begin
                            state_q    <= ST_DONE;
                            cpu_resetn <= 1'b1;
                        end else begin
                            state_q  <= ST_IDLE;
                            boot_err <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase

            // tmo_hit implies no byte this cycle, so it never races the case above.
            if (tmo_hit) begin
                state_q   <= ST_IDLE;
                boot_err  <= 1'b1;
                boot_busy <= 1'b0;
            end

            if (!in_frame || rx_valid || tmo_hit) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + TMO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: framing, checksum, timeout, noise, reset and DONE.
module tb_uart_boot_loader;

    localparam int unsigned AW  = 8;
    localparam int unsigned TMO = 20;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          ram_wen;
    logic [AW-1:0] ram_waddr;
    logic [31:0]   ram_wdata;
    logic          cpu_resetn;
    logic          boot_busy;
    logic          boot_err;

    int checks = 0;
    int errors = 0;
    int wr_count = 0;
    int wen_multi = 0;
    logic [AW-1:0] last_addr = '0;
    logic [31:0]   last_data = 32'd0;
    logic [31:0]   mem [0:255];
    logic          wen_prev = 1'b0;

    uart_boot_loader #(
        .RAM_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES (TMO),
        .SYNC_BYTE      (8'hA5)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .ram_wen    (ram_wen),
        .ram_waddr  (ram_waddr),
        .ram_wdata  (ram_wdata),
        .cpu_resetn (cpu_resetn),
        .boot_busy  (boot_busy),
        .boot_err   (boot_err)
    );

    always #5 clk = ~clk;

    // Write monitor acting as the boot RAM.
    always @(posedge clk) begin
        #1;
        if (ram_wen) begin
            wr_count++;
            last_addr = ram_waddr;
            last_data = ram_wdata;
            mem[ram_waddr] = ram_wdata;
            if (wen_prev) wen_multi++;
        end
        wen_prev = ram_wen;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_data  = 8'd0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rx_valid = 1'b0;
        resetn   = 1'b0;
        @(negedge clk);
        resetn   = 1'b1;
    endtask

    int wr_base;
    logic [7:0] csum;
    int bad_words;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;

        // Reset values
        #12;
        check("rst_wen",   {31'd0, ram_wen},    32'd0);
        check("rst_waddr", {24'd0, ram_waddr},  32'd0);
        check("rst_wdata", ram_wdata,           32'd0);
        check("rst_cpu",   {31'd0, cpu_resetn}, 32'd0);
        check("rst_busy",  {31'd0, boot_busy},  32'd0);
        check("rst_err",   {31'd0, boot_err},   32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Bad checksum: write still happens, error set, CPU held
        send(8'hA5); send(8'h00);
        check("bad_busy", {31'd0, boot_busy}, 32'd1);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        send(8'h15);
        idle(1);
        check("bad_wr_count", wr_count, 32'd1);
        check("bad_wdata",    last_data, 32'h1234_5678);
        check("bad_err",      {31'd0, boot_err},   32'd1);
        check("bad_cpu",      {31'd0, cpu_resetn}, 32'd0);
        check("bad_busy_off", {31'd0, boot_busy},  32'd0);

        // Noise, then a good one-word frame that also clears the error
        send(8'h00); send(8'hFF); send(8'h5A);
        idle(1);
        check("noise_busy", {31'd0, boot_busy}, 32'd0);
        check("noise_err",  {31'd0, boot_err},  32'd1);
        wr_base = wr_count;
        send(8'hA5); send(8'h00);
        check("good_err_clr", {31'd0, boot_err},  32'd0);
        check("good_busy",    {31'd0, boot_busy}, 32'd1);
        send(8'h78); send(8'h56); send(8'h34); send(8'h12);
        check("good_cpu_pre", {31'd0, cpu_resetn}, 32'd0);
        send(8'h14);
        idle(1);
        check("good_cpu",   {31'd0, cpu_resetn}, 32'd1);
        check("good_err",   {31'd0, boot_err},   32'd0);
        check("good_busy0", {31'd0, boot_busy},  32'd0);
        check("good_wrs",   wr_count - wr_base,  32'd1);
        check("good_waddr", {24'd0, last_addr},  32'd0);
        check("good_wdata", last_data,           32'h1234_5678);

        // Timeout: L=1, three bytes then silence
        do_reset();
        wr_base = wr_count;
        send(8'hA5); send(8'h01); send(8'h11); send(8'h22); send(8'h33);
        idle(1);
        idle(TMO - 3);
        check("tmo_busy_pre", {31'd0, boot_busy}, 32'd1);
        check("tmo_err_pre",  {31'd0, boot_err},  32'd0);
        idle(5);
        check("tmo_busy", {31'd0, boot_busy},  32'd0);
        check("tmo_err",  {31'd0, boot_err},   32'd1);
        check("tmo_cpu",  {31'd0, cpu_resetn}, 32'd0);
        check("tmo_nowr", wr_count - wr_base,  32'd0);

        // Reset mid-frame, after one word has been written
        send(8'hA5); send(8'h01);
        send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
        send(8'h01); send(8'h02);
        idle(1);
        check("mid_wdata_pre", ram_wdata, 32'hDEAD_BEEF);
        check("mid_busy_pre",  {31'd0, boot_busy}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("mid_wen",   {31'd0, ram_wen},    32'd0);
        check("mid_waddr", {24'd0, ram_waddr},  32'd0);
        check("mid_wdata", ram_wdata,           32'd0);
        check("mid_cpu",   {31'd0, cpu_resetn}, 32'd0);
        check("mid_busy",  {31'd0, boot_busy},  32'd0);
        check("mid_err",   {31'd0, boot_err},   32'd0);
        @(negedge clk);
        resetn = 1'b1;

        // Full load: 256 words, word i = i, back-to-back bytes
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_BEEF;
        wr_base = wr_count;
        csum = 8'd0;
        send(8'hA5); send(8'hFF);
        for (int w = 0; w < 256; w++) begin
            logic [31:0] wv;
            wv = w;
            for (int b = 0; b < 4; b++) begin
                send(wv[b*8 +: 8]);
                csum = csum + wv[b*8 +: 8];
            end
        end
        send(csum);
        idle(1);
        bad_words = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== 32'(i)) bad_words++;
        check("full_csum_val", {24'd0, csum},      32'h80);
        check("full_wrs",      wr_count - wr_base, 32'd256);
        check("full_data",     bad_words,          32'd0);
        check("full_last",     {24'd0, last_addr}, 32'd255);
        check("full_cpu",      {31'd0, cpu_resetn}, 32'd1);
        check("full_err",      {31'd0, boot_err},   32'd0);

        // Traffic after DONE is ignored
        wr_base = wr_count;
        send(8'hA5); send(8'h00); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
        send(8'h0A);
        idle(3);
        check("done_nowr", wr_count - wr_base, 32'd0);
        check("done_cpu",  {31'd0, cpu_resetn}, 32'd1);
        check("done_busy", {31'd0, boot_busy},  32'd0);
        check("wen_single", wen_multi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Bootloader write-port master that sits directly upstream of the boot RAM's write port. It consumes a byte stream from the SoC UART receiver, frames it (sync, length, payload, checksum), packs payload bytes little-endian into 32-bit words, and writes them to consecutive RAM addresses starting at 0. It holds the CPU in reset until a complete, checksum-valid image has been written.

## Interface
Parameters:
- RAM_ADDR_WIDTH, 8, RAM word-address width; must be ≥ 8.
- TIMEOUT_CYCLES, 1000000, idle cycles between bytes of one frame before the frame is aborted; must be ≥ 2.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clk  in  1  single clock for all logic.
- resetn  in  1  reset, asynchronous and active-low.
- rx_valid  in  1  one-cycle strobe; rx_data is valid. No backpressure; every strobe is one byte.
- rx_data  in  8  received byte.
- ram_wen  out  1  write strobe to the RAM write port, one cycle per word.
- ram_waddr  out  RAM_ADDR_WIDTH  word address.
- ram_wdata  out  32  word data.
- cpu_resetn  out  1  CPU reset; low until the load is DONE.
- boot_busy  out  1  high while a frame is in progress (LEN, DATA, CSUM).
- boot_err  out  1  sticky error flag; set on a checksum or timeout failure, cleared when the next SYNC_BYTE is accepted.

## Operation
- Frame format: SYNC_BYTE, L, then 4·(L+1) payload bytes, then C.
  - Word count is L+1, range 1..256.
  - C = 8-bit modulo-256 sum of all payload bytes.
- States:
  - IDLE: rx_valid with rx_data==SYNC_BYTE → LEN and clear boot_err. Any other byte is ignored.
  - LEN: byte → latch L, zero the word index, byte lane, and running sum → DATA.
  - DATA: each byte goes into lane 0..3 (lane 0 = bits 7:0) and is added to the sum. On lane 3 the word is written. After word L is written → CSUM.
  - CSUM: byte == sum → DONE; otherwise → IDLE with boot_err set.
  - DONE: terminal until resetn. cpu_resetn=1; all rx input is ignored.
- Timeout: in LEN, DATA or CSUM, a counter is reset on every rx_valid and incremented otherwise. When it reaches TIMEOUT_CYCLES → IDLE with boot_err set. Partially written RAM contents are left as they are.
- RAM is written before the checksum is known. This is safe because the CPU stays in reset. A failed frame is recovered by resending the whole frame.
- Word index is RAM_ADDR_WIDTH bits wide. With L=255 the last write goes to address 255; the index is never used beyond L.
- A SYNC_BYTE arriving mid-frame is treated as data, never as a resync.

## Timing
- Reset values: ram_wen=0, ram_waddr=0, ram_wdata=0, cpu_resetn=0, boot_busy=0, boot_err=0, state=IDLE.
- All outputs are registered.
- ram_wen pulses high for exactly one cycle, in the cycle after the rx_valid carrying lane 3. ram_waddr and ram_wdata are valid in that same cycle and hold until the next write.
- cpu_resetn rises in the cycle after the accepted checksum byte and stays high.
- boot_busy rises in the cycle after SYNC_BYTE is accepted. It falls in the cycle after leaving CSUM or after a timeout.
- boot_err updates in the same cycle the state leaves CSUM or times out.
- rx_valid may arrive on back-to-back cycles; every strobe must be accepted.
- Asserting resetn low mid-frame returns the block to reset values at once. RAM contents are not touched.

## Structure
- Shared package uart_boot_pkg holds:
  - the state encoding (IDLE, LEN, DATA, CSUM, DONE);
  - the SYNC_BYTE default;
  - the width of the timeout counter, derived from TIMEOUT_CYCLES.
- One sub-module, boot_word_packer: byte lane counter, 32-bit shift/assemble register, and a word-complete strobe. The top level owns the FSM, the word index, the checksum, and the timeout.

## Test plan
- One-word load: A5, 00, 78 56 34 12, 14 → one ram_wen with waddr=0, wdata=32'h12345678; cpu_resetn=1 one cycle after the 14; boot_err=0.
- Full load: L=FF with 1024 back-to-back bytes, pattern word i = i → 256 writes at addresses 0..255 with matching data, correct checksum → DONE.
- Bad checksum: one-word frame with C=15 → the write still occurs, boot_err=1, cpu_resetn stays 0. A following good frame clears boot_err and reaches DONE.
- Timeout: A5, 01, 3 bytes, then silence for TIMEOUT_CYCLES → IDLE, boot_err=1, boot_busy=0, no write issued.
- Noise before sync: bytes 00 FF 5A, then a valid frame → the noise is ignored, and the frame loads correctly.
- Reset mid-frame: assert resetn low during DATA → all outputs go to reset values at once. After release, a fresh frame loads normally; bytes sent after DONE produce no ram_wen.
